// File: rtl/av_dma_copy.sv
// Non-pipelined Avalon-MM word copier: read one word, write it, repeat; 2+READ_LATENCY cycles/word unstalled.
// Bus stalls hold every strobe, address and data stable; an abort takes effect only once the current transfer is accepted.
module av_dma_copy #(
  parameter int LEN_W        = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Start,
  input  logic             i_Abort,
  input  logic [29:0]      i_SrcAddr,
  input  logic [29:0]      i_DstAddr,
  input  logic [LEN_W-1:0] i_Len,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [LEN_W-1:0] o_WordsDone,
  output logic [29:0]      o_AV_Addr,
  output logic [3:0]       o_AV_ByteEn,
  output logic             o_AV_Read,
  output logic             o_AV_Write,
  output logic [31:0]      o_AV_WriteData,
  input  logic [31:0]      i_AV_ReadData,
  input  logic             i_AV_WaitRequest
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RWAIT, S_WR, S_DONE} state_t;

  localparam logic [2:0] LAT_INIT = 3'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  state_t           state_q, state_d;
  logic [29:0]      src_q, src_d;
  logic [29:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] words_q, words_d;
  logic [31:0]      data_q, data_d;
  logic [2:0]       lat_q, lat_d;
  logic             abort_q, abort_d;
  logic             abort_now;

  // An abort arriving on the very edge that ends a phase still counts.
  assign abort_now = abort_q | i_Abort;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    words_d = words_q;
    data_d  = data_q;
    lat_d   = lat_q;
    abort_d = abort_q;
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (i_Start) begin
          src_d   = i_SrcAddr;
          dst_d   = i_DstAddr;
          rem_d   = i_Len;
          words_d = '0;
          state_d = (i_Len == '0) ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        abort_d = abort_now;
        if (!i_AV_WaitRequest) begin
          if (READ_LATENCY == 0) begin
            if (abort_now) begin
              state_d = S_DONE;
            end else begin
              data_d  = i_AV_ReadData;
              state_d = S_WR;
            end
          end else begin
            lat_d   = LAT_INIT;
            state_d = S_RWAIT;
          end
        end
      end
      S_RWAIT: begin
        abort_d = abort_now;
        if (lat_q == 3'd0) begin
          if (abort_now) begin
            state_d = S_DONE;
          end else begin
            data_d  = i_AV_ReadData;
            state_d = S_WR;
          end
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      S_WR: begin
        abort_d = abort_now;
        if (!i_AV_WaitRequest) begin
          src_d   = src_q + 30'd1;
          dst_d   = dst_q + 30'd1;
          words_d = words_q + LEN_W'(1);
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1) || abort_now) ? S_DONE : S_RD;
        end
      end
      S_DONE: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      words_q <= '0;
      data_q  <= '0;
      lat_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      data_q  <= data_d;
      lat_q   <= lat_d;
      abort_q <= abort_d;
    end
  end

  assign o_AV_Read      = (state_q == S_RD);
  assign o_AV_Write     = (state_q == S_WR);
  assign o_AV_ByteEn    = (o_AV_Read || o_AV_Write) ? 4'hF : 4'h0;
  assign o_AV_Addr      = o_AV_Read ? src_q : (o_AV_Write ? dst_q : 30'd0);
  assign o_AV_WriteData = o_AV_Write ? data_q : 32'd0;
  assign o_Busy         = (state_q == S_RD) || (state_q == S_RWAIT) || (state_q == S_WR);
  assign o_Done         = (state_q == S_DONE);
  assign o_WordsDone    = words_q;

endmodule
